// File: rtl/ahb_burst_addr_gen.sv
// AHB manager address-phase generator: one burst request in, beat-by-beat HADDR/HTRANS out.
// Optional build macro AHB_BURST_1KB_SPLIT_EN restarts INCR bursts as NONSEQ at 1KB boundaries.
module ahb_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 4
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [2:0]             req_burst,
  input  logic [2:0]             req_size,
  input  logic                   req_write,
  input  logic [LENGTH:0]        req_len,
  input  logic [2**LENGTH-1:0]   req_busy_mask,
  output logic [ADDR_WIDTH-1:0]  haddr,
  output logic [1:0]             htrans,
  output logic [2:0]             hburst,
  output logic [2:0]             hsize,
  output logic                   hwrite,
  input  logic                   hready,
  input  logic                   hresp,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             dbg_state
);

  localparam logic [1:0] TR_IDLE = 2'd0, TR_BUSY = 2'd1, TR_NONSEQ = 2'd2, TR_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));
  localparam logic [LENGTH:0] LEN_MAX = {1'b1, {LENGTH{1'b0}}};
  localparam logic [LENGTH:0] BEATS_1 = 1, BEATS_4 = 4, BEATS_8 = 8, BEATS_16 = 16;
  localparam logic [LENGTH-1:0] BEAT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BUSY, S_DRAIN, S_ERR1} state_t;
  state_t state_q, state_d;

  logic [LENGTH-1:0]     beat_q, last_q, beat_nx;
  logic                  first_q, wrap_q, is_last, illegal, err_start;
  logic [2**LENGTH-1:0]  busy_q;
  logic [ADDR_WIDTH-1:0] wmask_q, step, inc_addr, next_addr, align_mask;
  logic [LENGTH:0]       req_beats;

  always_comb begin
    req_beats = BEATS_1;
    case (req_burst)
      B_SINGLE:    req_beats = BEATS_1;
      B_INCR:      req_beats = req_len;
      3'd2, 3'd3:  req_beats = BEATS_4;
      3'd4, 3'd5:  req_beats = BEATS_8;
      default:     req_beats = BEATS_16;
    endcase
  end

  assign illegal    = (req_size > MAX_SIZE) ||
                      ((req_burst == B_INCR) && ((req_len == '0) || (req_len > LEN_MAX)));
  assign align_mask = ~((ADDR_ONE << req_size) - ADDR_ONE);
  assign step       = ADDR_ONE << hsize;
  assign inc_addr   = haddr + step;
  assign next_addr  = wrap_q ? ((haddr & ~wmask_q) | (inc_addr & wmask_q)) : inc_addr;
  assign beat_nx    = beat_q + BEAT_ONE;
  assign is_last    = (beat_q == last_q);
  // Every bus-side state except IDLE treats hresp=1 with hready=0 as the first error cycle.
  assign err_start  = hresp && !hready;

  // Request handshake: a request is taken on any edge where req_valid && req_ready; req_ready
  // is high only in IDLE, and the request fields are sampled only on that edge.
  assign req_ready = (state_q == S_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid && !illegal) state_d = S_ADDR;
      S_ADDR:  if (err_start) state_d = S_ERR1;
               else if (hready) state_d = is_last ? S_DRAIN : (busy_q[beat_nx] ? S_BUSY : S_ADDR);
      S_BUSY:  state_d = err_start ? S_ERR1 : S_ADDR;
      S_DRAIN: if (err_start) state_d = S_ERR1;
               else if (hready) state_d = S_IDLE;
      S_ERR1:  if (hready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    htrans = TR_IDLE;
    case (state_q)
      S_ADDR:  htrans = first_q ? TR_NONSEQ : TR_SEQ;
      S_BUSY:  htrans = TR_BUSY;
      default: htrans = TR_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr   <= '0;
      hburst  <= B_SINGLE;
      hsize   <= 3'd0;
      hwrite  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      beat_q  <= '0;
      last_q  <= '0;
      first_q <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= '0;
      wmask_q <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          if (illegal) begin
            err <= 1'b1;
          end else begin
            haddr   <= req_addr & align_mask;
            hburst  <= req_burst;
            hsize   <= req_size;
            hwrite  <= req_write;
            beat_q  <= '0;
            last_q  <= LENGTH'(req_beats - BEATS_1);
            first_q <= 1'b1;
            busy_q  <= req_busy_mask;
            wrap_q  <= (req_burst == 3'd2) || (req_burst == 3'd4) || (req_burst == 3'd6);
            wmask_q <= (ADDR_WIDTH'(req_beats) << req_size) - ADDR_ONE;
          end
        end
        S_ADDR: if (hready && !is_last) begin
          // In BUSY the address already shows the upcoming beat, so it advances here.
          haddr   <= next_addr;
          beat_q  <= beat_nx;
          first_q <= 1'b0;
`ifdef AHB_BURST_1KB_SPLIT_EN
          if (!wrap_q && (next_addr[9:0] == 10'd0)) begin
            first_q <= 1'b1;
            hburst  <= B_INCR;
          end
`endif
        end
        S_DRAIN: if (hready) begin
          done <= !hresp;
          err  <= hresp;
        end
        S_ERR1: if (hready) err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Directed bench for ahb_burst_addr_gen: burst sequences, BUSY, wait states, errors, 1KB split.
module tb_ahb_burst_addr_gen;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
`ifdef AHB_BURST_1KB_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        hclk = 1'b0, hreset = 1'b1, req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0, haddr;
  logic [2:0]  req_burst = '0, req_size = '0, hburst, hsize, dbg_state;
  logic        req_write = 1'b0, hwrite, hready = 1'b1, hresp = 1'b0, done, err;
  logic [4:0]  req_len = '0;
  logic [15:0] req_busy_mask = '0;
  logic [1:0]  htrans;

  int tests_run = 0;
  int tests_failed = 0;

  ahb_burst_addr_gen dut (
    .hclk(hclk), .hreset(hreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_burst(req_burst), .req_size(req_size), .req_write(req_write),
    .req_len(req_len), .req_busy_mask(req_busy_mask), .haddr(haddr), .htrans(htrans),
    .hburst(hburst), .hsize(hsize), .hwrite(hwrite), .hready(hready), .hresp(hresp),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 hclk = ~hclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

  // Called at a negedge while idle; returns at the negedge where beat 0 is visible.
  task automatic issue(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                       input logic w, input logic [4:0] l, input logic [15:0] m);
    req_addr = a; req_burst = b; req_size = s; req_write = w; req_len = l; req_busy_mask = m;
    req_valid = 1'b1;
    @(negedge hclk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    repeat (3) @(negedge hclk);
    tests_run++;
    if ({htrans, haddr, hburst, hsize, hwrite, done, err, req_ready} !==
        {T_IDLE, 32'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset: htrans=%0d haddr=%h hburst=%0d hsize=%0d hwrite=%b done=%b err=%b rdy=%b",
               htrans, haddr, hburst, hsize, hwrite, done, err, req_ready);
    end
    hreset = 1'b0;
    @(negedge hclk);
    tests_run++;
    if (htrans !== T_IDLE || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: htrans=%0d rdy=%b expected 0/1", htrans, req_ready);
    end
  endtask

  task automatic test_incr4();
    logic [31:0] ea[4];
    ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
    issue(32'h100, 3'd3, 3'd2, 1'b1, 5'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (htrans !== (i == 0 ? T_NSEQ : T_SEQ) || haddr !== ea[i] || hburst !== 3'd3 ||
          hsize !== 3'd2 || hwrite !== 1'b1) begin
        tests_failed++;
        $display("FAIL incr4 beat %0d: htrans=%0d haddr=%h hburst=%0d hsize=%0d hwrite=%b expected %0d %h 3 2 1",
                 i, htrans, haddr, hburst, hsize, hwrite, (i == 0 ? T_NSEQ : T_SEQ), ea[i]);
      end
      @(negedge hclk);
    end
    tests_run++;
    if (htrans !== T_IDLE || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL incr4_drain: htrans=%0d done=%b expected 0/0", htrans, done);
    end
    @(negedge hclk);
    tests_run++;
    if (done !== 1'b1 || err !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL incr4_done: done=%b err=%b rdy=%b expected 1/0/1", done, err, req_ready);
    end
    @(negedge hclk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL incr4_done_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_wrap4();
    logic [31:0] ea[4];
    ea = '{32'h38, 32'h3C, 32'h30, 32'h34};
    issue(32'h38, 3'd2, 3'd2, 1'b0, 5'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (htrans !== (i == 0 ? T_NSEQ : T_SEQ) || haddr !== ea[i] || hburst !== 3'd2) begin
        tests_failed++;
        $display("FAIL wrap4 beat %0d: htrans=%0d haddr=%h hburst=%0d expected %0d %h 2",
                 i, htrans, haddr, hburst, (i == 0 ? T_NSEQ : T_SEQ), ea[i]);
      end
      @(negedge hclk);
    end
    @(negedge hclk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap4_done: done=%b expected 1", done);
    end
    @(negedge hclk);
  endtask

  task automatic test_busy();
    logic [31:0] ea[5];
    logic [1:0]  et[5];
    ea = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC};
    et = '{T_NSEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ};
    issue(32'h0, 3'd3, 3'd2, 1'b1, 5'd0, 16'b0100);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (htrans !== et[i] || haddr !== ea[i]) begin
        tests_failed++;
        $display("FAIL busy cycle %0d: htrans=%0d haddr=%h expected %0d %h", i, htrans, haddr, et[i], ea[i]);
      end
      @(negedge hclk);
    end
    @(negedge hclk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_done: done=%b expected 1", done);
    end
    @(negedge hclk);
  endtask

  task automatic test_wait_states();
    logic [31:0] ea[10];
    ea = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h20C, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C};
    issue(32'h200, 3'd5, 3'd2, 1'b0, 5'd0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (htrans !== (i == 0 ? T_NSEQ : T_SEQ) || haddr !== ea[i]) begin
        tests_failed++;
        $display("FAIL wait cycle %0d: htrans=%0d haddr=%h expected %0d %h",
                 i, htrans, haddr, (i == 0 ? T_NSEQ : T_SEQ), ea[i]);
      end
      hready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      @(negedge hclk);
    end
    tests_run++;
    if (htrans !== T_IDLE) begin
      tests_failed++;
      $display("FAIL wait_drain: htrans=%0d expected 0", htrans);
    end
    @(negedge hclk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_done: done=%b expected 1", done);
    end
    @(negedge hclk);
  endtask

  task automatic test_error();
    issue(32'h0, 3'd3, 3'd2, 1'b1, 5'd0, 16'h0);
    @(negedge hclk);
    @(negedge hclk);
    tests_run++;
    if (htrans !== T_SEQ || haddr !== 32'h8) begin
      tests_failed++;
      $display("FAIL err_beat2: htrans=%0d haddr=%h expected 3 00000008", htrans, haddr);
    end
    hresp = 1'b1; hready = 1'b0;
    @(negedge hclk);
    tests_run++;
    if (htrans !== T_IDLE || done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_idle: htrans=%0d done=%b err=%b rdy=%b expected 0/0/0/0", htrans, done, err, req_ready);
    end
    hready = 1'b1;
    @(negedge hclk);
    hresp = 1'b0;
    tests_run++;
    if (err !== 1'b1 || done !== 1'b0 || req_ready !== 1'b1 || htrans !== T_IDLE) begin
      tests_failed++;
      $display("FAIL err_pulse: err=%b done=%b rdy=%b htrans=%0d expected 1/0/1/0", err, done, req_ready, htrans);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      tests_run++;
      if (err !== 1'b0 || done !== 1'b0 || htrans !== T_IDLE) begin
        tests_failed++;
        $display("FAIL err_after %0d: err=%b done=%b htrans=%0d expected 0/0/0", i, err, done, htrans);
      end
    end
  endtask

  task automatic test_1kb();
    logic [31:0] ea[4];
    logic [1:0]  et[4];
    logic [2:0]  eb[4];
    ea = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    et = '{T_NSEQ, T_SEQ, (SPLIT ? T_NSEQ : T_SEQ), T_SEQ};
    issue(32'h3F8, 3'd1, 3'd2, 1'b1, 5'd4, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (htrans !== et[i] || haddr !== ea[i] || hburst !== 3'd1) begin
        tests_failed++;
        $display("FAIL 1kb_incr beat %0d: htrans=%0d haddr=%h hburst=%0d expected %0d %h 1",
                 i, htrans, haddr, hburst, et[i], ea[i]);
      end
      @(negedge hclk);
    end
    repeat (2) @(negedge hclk);
    ea = '{32'h7F8, 32'h7FC, 32'h800, 32'h804};
    eb = '{3'd3, 3'd3, (SPLIT ? 3'd1 : 3'd3), (SPLIT ? 3'd1 : 3'd3)};
    issue(32'h7F8, 3'd3, 3'd2, 1'b1, 5'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (htrans !== et[i] || haddr !== ea[i] || hburst !== eb[i]) begin
        tests_failed++;
        $display("FAIL 1kb_incr4 beat %0d: htrans=%0d haddr=%h hburst=%0d expected %0d %h %0d",
                 i, htrans, haddr, hburst, et[i], ea[i], eb[i]);
      end
      @(negedge hclk);
    end
    @(negedge hclk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL 1kb_done: done=%b expected 1", done);
    end
    @(negedge hclk);
  endtask

  task automatic test_illegal();
    logic [2:0] bs[4], ss[4];
    logic [4:0] ls[4];
    bs = '{3'd3, 3'd1, 3'd1, 3'd0};
    ss = '{3'd3, 3'd2, 3'd2, 3'd4};
    ls = '{5'd4, 5'd0, 5'd17, 5'd1};
    for (int i = 0; i < 4; i++) begin
      issue(32'h40, bs[i], ss[i], 1'b0, ls[i], 16'h0);
      tests_run++;
      if (err !== 1'b1 || done !== 1'b0 || htrans !== T_IDLE || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL illegal %0d: err=%b done=%b htrans=%0d rdy=%b expected 1/0/0/1", i, err, done, htrans, req_ready);
      end
      @(negedge hclk);
      tests_run++;
      if (err !== 1'b0 || htrans !== T_IDLE) begin
        tests_failed++;
        $display("FAIL illegal_after %0d: err=%b htrans=%0d expected 0/0", i, err, htrans);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(32'h55, 3'd0, 3'd1, 1'b0, 5'd0, 16'h0);
    tests_run++;
    if (htrans !== T_NSEQ || haddr !== 32'h54 || hburst !== 3'd0 || hsize !== 3'd1 || hwrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_single: htrans=%0d haddr=%h hburst=%0d hsize=%0d hwrite=%b expected 2 00000054 0 1 0",
               htrans, haddr, hburst, hsize, hwrite);
    end
    repeat (2) @(negedge hclk);
    tests_run++;
    if (done !== 1'b1 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_single_done: done=%b rdy=%b expected 1/1", done, req_ready);
    end
    issue(32'h7, 3'd1, 3'd0, 1'b1, 5'd2, 16'h0);
    tests_run++;
    if (htrans !== T_NSEQ || haddr !== 32'h7 || hburst !== 3'd1 || hsize !== 3'd0) begin
      tests_failed++;
      $display("FAIL b2b_beat0: htrans=%0d haddr=%h hburst=%0d hsize=%0d expected 2 00000007 1 0",
               htrans, haddr, hburst, hsize);
    end
    @(negedge hclk);
    tests_run++;
    if (htrans !== T_SEQ || haddr !== 32'h8) begin
      tests_failed++;
      $display("FAIL b2b_beat1: htrans=%0d haddr=%h expected 3 00000008", htrans, haddr);
    end
    repeat (2) @(negedge hclk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done: done=%b expected 1", done);
    end
    @(negedge hclk);
  endtask

  task automatic test_reset_mid();
    issue(32'h200, 3'd5, 3'd2, 1'b0, 5'd0, 16'h0);
    repeat (2) @(negedge hclk);
    hreset = 1'b1;
    @(negedge hclk);
    tests_run++;
    if (htrans !== T_IDLE || req_ready !== 1'b1 || haddr !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: htrans=%0d rdy=%b haddr=%h done=%b err=%b expected 0/1/0/0/0",
               htrans, req_ready, haddr, done, err);
    end
    hreset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge hclk);
      tests_run++;
      if (htrans !== T_IDLE || done !== 1'b0 || err !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_after %0d: htrans=%0d done=%b err=%b expected 0/0/0", i, htrans, done, err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr4();
    test_wrap4();
    test_busy();
    test_wait_states();
    test_error();
    test_1kb();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
